// File: rtl/otp_ctrl_chk_sched.sv
// Serialises timer integrity/consistency check requests onto one partition at a time (RR, integ first); grant 1 cycle after request, ack 1 cycle after done.
// otp_prog_busy_i holds off new grants only; optional grant watchdog via OTP_CTRL_CHK_SCHED_WDOG_EN. escalate_en_i uses lc_tx_t encoding (Off = 4'b1010).
module otp_ctrl_chk_sched #(
  parameter int unsigned NumReq    = 10,
  parameter int unsigned WdogWidth = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] integ_req_i,
  input  logic [NumReq-1:0] cnsty_req_i,
  output logic [NumReq-1:0] integ_ack_o,
  output logic [NumReq-1:0] cnsty_ack_o,
  output logic [NumReq-1:0] part_integ_req_o,
  output logic [NumReq-1:0] part_cnsty_req_o,
  input  logic [NumReq-1:0] part_done_i,
  input  logic              otp_prog_busy_i,
  input  logic [31:0]       timeout_i,
  input  logic [3:0]        escalate_en_i,
  output logic [15:0]       chk_cnt_o,
  output logic              wdog_timeout_o,
  output logic              fsm_err_o
);

  localparam int unsigned IdxW    = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam logic [3:0]  LcTxOff = 4'b1010;

  // Pairwise Hamming distance >= 3.
  localparam logic [5:0] IdleSt     = 6'b000111;
  localparam logic [5:0] IntegGntSt = 6'b111000;
  localparam logic [5:0] CnstyGntSt = 6'b011011;
  localparam logic [5:0] ErrorSt    = 6'b101101;

  logic [5:0]        state_d, state_q;
  logic [IdxW-1:0]   idx_d, idx_q;
  logic [IdxW-1:0]   ptr_d, ptr_q;
  logic [NumReq-1:0] integ_ack_d, integ_ack_q;
  logic [NumReq-1:0] cnsty_ack_d, cnsty_ack_q;
  logic [15:0]       cnt_d, cnt_q;
  logic              fsm_err_d, fsm_err_q;
  logic [NumReq-1:0] integ_eff, cnsty_eff, idx_oh;
  logic              gnt_done, wdog_expire, in_gnt;

  function automatic logic [IdxW-1:0] rr_pick(input logic [NumReq-1:0] req,
                                               input logic [IdxW-1:0]   ptr);
    logic [IdxW-1:0] sel;
    logic            found;
    int              j;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < int'(NumReq); i++) begin
      j = int'(ptr) + i;
      if (j >= int'(NumReq)) j = j - int'(NumReq);
      if (!found && req[j]) begin
        found = 1'b1;
        sel   = IdxW'(j);
      end
    end
    return sel;
  endfunction

  always_comb begin
    idx_oh = '0;
    for (int i = 0; i < int'(NumReq); i++) idx_oh[i] = (idx_q == IdxW'(i));
  end

  // A request bit is still high during its ack cycle; mask it so it is not re-granted.
  assign integ_eff = integ_req_i & ~integ_ack_q;
  assign cnsty_eff = cnsty_req_i & ~cnsty_ack_q;
  assign gnt_done  = part_done_i[idx_q];
  assign in_gnt    = (state_q == IntegGntSt) || (state_q == CnstyGntSt);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    integ_ack_d = '0;
    cnsty_ack_d = '0;
    cnt_d       = cnt_q;
    fsm_err_d   = fsm_err_q;
    case (state_q)
      IdleSt: begin
        if (!otp_prog_busy_i) begin
          if (|integ_eff) begin
            idx_d   = rr_pick(integ_eff, ptr_q);
            state_d = IntegGntSt;
          end else if (|cnsty_eff) begin
            idx_d   = rr_pick(cnsty_eff, ptr_q);
            state_d = CnstyGntSt;
          end
        end
      end
      IntegGntSt, CnstyGntSt: begin
        if (gnt_done) begin
          state_d = IdleSt;
          if (state_q == IntegGntSt) integ_ack_d = idx_oh;
          else                       cnsty_ack_d = idx_oh;
          ptr_d = (idx_q == IdxW'(NumReq - 1)) ? '0 : idx_q + 1'b1;
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end else if (wdog_expire) begin
          state_d = ErrorSt;
        end
      end
      ErrorSt: ;
      default: begin
        state_d   = ErrorSt;
        fsm_err_d = 1'b1;
      end
    endcase
    // Anything other than Off counts as escalation.
    if (escalate_en_i != LcTxOff) begin
      state_d     = ErrorSt;
      fsm_err_d   = 1'b1;
      integ_ack_d = '0;
      cnsty_ack_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IdleSt;
      idx_q       <= '0;
      ptr_q       <= '0;
      integ_ack_q <= '0;
      cnsty_ack_q <= '0;
      cnt_q       <= '0;
      fsm_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      integ_ack_q <= integ_ack_d;
      cnsty_ack_q <= cnsty_ack_d;
      cnt_q       <= cnt_d;
      fsm_err_q   <= fsm_err_d;
    end
  end

`ifdef OTP_CTRL_CHK_SCHED_WDOG_EN
  logic [WdogWidth-1:0] wdog_cnt_d, wdog_cnt_q;
  logic                 wdog_armed_d, wdog_armed_q;
  logic                 wdog_to_d, wdog_to_q;
  logic [WdogWidth-1:0] wdog_load;

  assign wdog_load = WdogWidth'(timeout_i);
  // Expire on the cycle the counter would step from 1 to 0; a same-cycle done wins.
  assign wdog_expire = in_gnt && wdog_armed_q && (wdog_cnt_q == WdogWidth'(1));

  always_comb begin
    wdog_cnt_d   = wdog_cnt_q;
    wdog_armed_d = wdog_armed_q;
    wdog_to_d    = wdog_to_q | (wdog_expire & ~gnt_done);
    if (state_q == IdleSt && (state_d == IntegGntSt || state_d == CnstyGntSt)) begin
      wdog_cnt_d   = wdog_load;
      wdog_armed_d = |wdog_load;
    end else if (in_gnt && wdog_cnt_q != '0) begin
      wdog_cnt_d = wdog_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_cnt_q   <= '0;
      wdog_armed_q <= 1'b0;
      wdog_to_q    <= 1'b0;
    end else begin
      wdog_cnt_q   <= wdog_cnt_d;
      wdog_armed_q <= wdog_armed_d;
      wdog_to_q    <= wdog_to_d;
    end
  end

  assign wdog_timeout_o = wdog_to_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^{timeout_i, WdogWidth};
  assign wdog_expire    = 1'b0;
  assign wdog_timeout_o = 1'b0;
`endif

  assign part_integ_req_o = (state_q == IntegGntSt) ? idx_oh : '0;
  assign part_cnsty_req_o = (state_q == CnstyGntSt) ? idx_oh : '0;
  assign integ_ack_o      = integ_ack_q;
  assign cnsty_ack_o      = cnsty_ack_q;
  assign chk_cnt_o        = cnt_q;
  assign fsm_err_o        = fsm_err_q;

endmodule

// File: tb/tb_otp_ctrl_chk_sched.sv
// Directed bench for otp_ctrl_chk_sched with NumReq=4; a small timer/partition model returns done after done_lat grant cycles.
module tb_otp_ctrl_chk_sched;
  localparam int N = 4;
  localparam logic [3:0] LcOn  = 4'b0101;
  localparam logic [3:0] LcOff = 4'b1010;
  localparam logic [5:0] BadSt = 6'b000000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] integ_req = '0, cnsty_req = '0, part_done = '0;
  logic         busy = 1'b0;
  logic [31:0]  timeout = '0;
  logic [3:0]   esc = LcOff;
  logic [N-1:0] integ_ack, cnsty_ack, p_integ, p_cnsty;
  logic [15:0]  chk_cnt;
  logic         wdog_to, fsm_err;

  int n_checks = 0;
  int n_fail   = 0;
  int done_lat = 2;  // 0: model never returns done
  int age      = 0;
  logic [N-1:0] cur;

  otp_ctrl_chk_sched #(.NumReq(N), .WdogWidth(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .integ_req_i(integ_req), .cnsty_req_i(cnsty_req),
    .integ_ack_o(integ_ack), .cnsty_ack_o(cnsty_ack),
    .part_integ_req_o(p_integ), .part_cnsty_req_o(p_cnsty),
    .part_done_i(part_done), .otp_prog_busy_i(busy),
    .timeout_i(timeout), .escalate_en_i(esc),
    .chk_cnt_o(chk_cnt), .wdog_timeout_o(wdog_to), .fsm_err_o(fsm_err)
  );

  always #5 clk = ~clk;

  // Timer drops a request once acked; partition answers done_lat cycles into a grant.
  always @(negedge clk) begin
    integ_req = integ_req & ~integ_ack;
    cnsty_req = cnsty_req & ~cnsty_ack;
    cur = p_integ | p_cnsty;
    if (cur == '0) age = 0;
    else           age = age + 1;
    if (done_lat != 0) part_done = (cur != '0 && age == done_lat) ? cur : '0;
  end

  task automatic do_reset();
    integ_req = '0; cnsty_req = '0; part_done = '0; busy = 1'b0; esc = LcOff;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({p_integ, p_cnsty, integ_ack, cnsty_ack} !== '0) begin
      n_fail++; $display("FAIL reset_grants_acks: got %h want 0", {p_integ, p_cnsty, integ_ack, cnsty_ack});
    end
    n_checks++;
    if ({chk_cnt, wdog_to, fsm_err} !== '0) begin
      n_fail++; $display("FAIL reset_status: got cnt=%h wdog=%b err=%b want 0", chk_cnt, wdog_to, fsm_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({p_integ, p_cnsty, fsm_err} !== '0) begin
      n_fail++; $display("FAIL post_reset_idle: got %h want 0", {p_integ, p_cnsty, fsm_err});
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_seq [3];
    logic [N-1:0] g, prev_g;
    int cyc, n_g, n_a, g_cyc, a_cyc;
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b1000;
    cyc = 0; n_g = 0; n_a = 0; g_cyc = 0; a_cyc = 0; prev_g = '0;
    done_lat = 2;
    integ_req = 4'b1011;
    while (n_a < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      g = p_integ;
      if (g != '0 && g != prev_g) begin
        n_checks++;
        if (n_g >= 3 || g !== exp_seq[n_g]) begin
          n_fail++; $display("FAIL rr_grant_order #%0d: got %b", n_g, g);
        end
        if (n_g > 0) begin
          n_checks++;
          if (cyc - a_cyc != 1) begin
            n_fail++; $display("FAIL rr_regrant_gap: got %0d cycles after ack want 1", cyc - a_cyc);
          end
        end
        g_cyc = cyc; n_g++;
      end
      if (integ_ack != '0) begin
        n_checks++;
        if (n_a >= 3 || integ_ack !== exp_seq[n_a]) begin
          n_fail++; $display("FAIL rr_ack #%0d: got %b", n_a, integ_ack);
        end
        n_checks++;
        if (cyc - g_cyc != 2 || g != '0) begin
          n_fail++; $display("FAIL rr_ack_timing: got %0d cycles grant=%b want 2 and grant 0", cyc - g_cyc, g);
        end
        a_cyc = cyc; n_a++;
      end
      prev_g = g;
    end
    n_checks++;
    if (n_a != 3) begin
      n_fail++; $display("FAIL rr_timeout: got %0d acks want 3", n_a);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (chk_cnt !== 16'd3 || p_integ !== '0) begin
      n_fail++; $display("FAIL rr_count: got cnt=%0d grant=%b want 3 and 0", chk_cnt, p_integ);
    end
  endtask

  task automatic test_integ_priority();
    int cyc, ia, cg, ca;
    cyc = 0; ia = 0; cg = 0; ca = 0;
    done_lat = 2;
    integ_req = 4'b0100; cnsty_req = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (p_integ !== 4'b0100 || p_cnsty !== '0) begin
      n_fail++; $display("FAIL prio_first: got integ=%b cnsty=%b want 0100/0000", p_integ, p_cnsty);
    end
    while (ca == 0 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (p_integ != '0 && p_cnsty != '0) begin
        n_checks++; n_fail++; $display("FAIL prio_both_granted: %b %b", p_integ, p_cnsty);
      end
      if (integ_ack != '0) ia = cyc;
      if (p_cnsty != '0 && cg == 0) begin
        cg = cyc;
        n_checks++;
        if (p_cnsty !== 4'b0100) begin
          n_fail++; $display("FAIL prio_cnsty_grant: got %b want 0100", p_cnsty);
        end
      end
      if (cnsty_ack != '0) begin
        ca = cyc;
        n_checks++;
        if (cnsty_ack !== 4'b0100) begin
          n_fail++; $display("FAIL prio_cnsty_ack: got %b want 0100", cnsty_ack);
        end
      end
    end
    n_checks++;
    if (ia == 0 || cg != ia + 1 || ca == 0) begin
      n_fail++; $display("FAIL prio_order: got integ_ack@%0d cnsty_gnt@%0d cnsty_ack@%0d", ia, cg, ca);
    end
    @(negedge clk);
    n_checks++;
    if (chk_cnt !== 16'd5) begin
      n_fail++; $display("FAIL prio_count: got %0d want 5", chk_cnt);
    end
  endtask

  task automatic test_busy();
    done_lat = 0;
    busy = 1'b1; cnsty_req = 4'b0001;
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if ((p_integ | p_cnsty) !== '0) begin
        n_fail++; $display("FAIL busy_blocks: got %b want 0", p_integ | p_cnsty);
      end
    end
    busy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (p_cnsty !== 4'b0001) begin
      n_fail++; $display("FAIL busy_release_grant: got %b want 0001", p_cnsty);
    end
    busy = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (p_cnsty !== 4'b0001) begin
      n_fail++; $display("FAIL busy_midgrant_hold: got %b want 0001", p_cnsty);
    end
    part_done = 4'b0010;
    @(negedge clk);
    part_done = '0;
    n_checks++;
    if (p_cnsty !== 4'b0001 || cnsty_ack !== '0) begin
      n_fail++; $display("FAIL wrong_done_ignored: got gnt=%b ack=%b want 0001/0000", p_cnsty, cnsty_ack);
    end
    part_done = 4'b0001;
    @(negedge clk);
    part_done = '0;
    n_checks++;
    if (cnsty_ack !== 4'b0001 || p_cnsty !== '0) begin
      n_fail++; $display("FAIL busy_done_ack: got ack=%b gnt=%b want 0001/0000", cnsty_ack, p_cnsty);
    end
    @(negedge clk);
    n_checks++;
    if (cnsty_ack !== '0) begin
      n_fail++; $display("FAIL ack_single_pulse: got %b want 0", cnsty_ack);
    end
    busy = 1'b0;
  endtask

  task automatic test_escalation();
    done_lat = 0;
    integ_req = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (p_integ !== 4'b0001) begin
      n_fail++; $display("FAIL esc_pre_grant: got %b want 0001", p_integ);
    end
    esc = LcOn;
    @(negedge clk);
    n_checks++;
    if (fsm_err !== 1'b1 || (p_integ | p_cnsty | integ_ack | cnsty_ack) !== '0) begin
      n_fail++; $display("FAIL esc_enter: got err=%b outs=%b want 1/0", fsm_err, p_integ | p_cnsty | integ_ack | cnsty_ack);
    end
    esc = LcOff;
    integ_req = 4'b1111; cnsty_req = 4'b1111; part_done = 4'b1111;
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if (fsm_err !== 1'b1 || (p_integ | p_cnsty | integ_ack | cnsty_ack) !== '0) begin
        n_fail++; $display("FAIL esc_terminal: got err=%b outs=%b want 1/0", fsm_err, p_integ | p_cnsty | integ_ack | cnsty_ack);
      end
    end
    do_reset();
    esc = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (fsm_err !== 1'b1) begin
      n_fail++; $display("FAIL esc_loose_idle: got %b want 1", fsm_err);
    end
    do_reset();
  endtask

  task automatic test_watchdog();
    int cyc, g_cyc, w_cyc;
    done_lat = 0;
`ifdef OTP_CTRL_CHK_SCHED_WDOG_EN
    cyc = 0; g_cyc = -1; w_cyc = -1;
    timeout = 32'd5;
    integ_req = 4'b0001;
    while (w_cyc < 0 && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (p_integ != '0 && g_cyc < 0) g_cyc = cyc;
      if (wdog_to) w_cyc = cyc;
    end
    n_checks++;
    if (g_cyc < 0 || w_cyc < 0 || w_cyc - g_cyc > 6) begin
      n_fail++; $display("FAIL wdog_expiry: got grant@%0d wdog@%0d want within 6", g_cyc, w_cyc);
    end
    n_checks++;
    if (p_integ !== '0 || fsm_err !== 1'b0 || integ_ack !== '0) begin
      n_fail++; $display("FAIL wdog_state: got gnt=%b err=%b ack=%b want 0/0/0", p_integ, fsm_err, integ_ack);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (wdog_to !== 1'b1) begin
      n_fail++; $display("FAIL wdog_sticky: got %b want 1", wdog_to);
    end
    do_reset();
    timeout = 32'd0;
`else
    cyc = 0; g_cyc = 0; w_cyc = 0;
    timeout = 32'd5;
`endif
    integ_req = 4'b0001;
    repeat (20) @(negedge clk);
    n_checks++;
    if (p_integ !== 4'b0001 || wdog_to !== 1'b0 || fsm_err !== 1'b0) begin
      n_fail++; $display("FAIL wdog_disabled_hold: got gnt=%b wdog=%b err=%b want 0001/0/0", p_integ, wdog_to, fsm_err);
    end
    do_reset();
    timeout = 32'd0;
  endtask

  task automatic test_illegal_state();
    int cyc;
    logic seen;
    cyc = 0; seen = 1'b0;
    done_lat = 2;
    integ_req = 4'b0100;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (integ_ack != '0) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL illegal_setup_ack: got none want 0100");
    end
    done_lat = 0;
    integ_req = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (p_integ !== 4'b0010) begin
      n_fail++; $display("FAIL rr_wrap_grant: got %b want 0010", p_integ);
    end
    force dut.state_q = BadSt;
    @(negedge clk);
    n_checks++;
    if (fsm_err !== 1'b1 || (p_integ | p_cnsty) !== '0) begin
      n_fail++; $display("FAIL illegal_state_err: got err=%b gnt=%b want 1/0", fsm_err, p_integ | p_cnsty);
    end
    release dut.state_q;
    integ_req = 4'b0010;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    integ_req = '0;
    @(negedge clk);
    n_checks++;
    if ({p_integ, p_cnsty, integ_ack, cnsty_ack, chk_cnt, wdog_to, fsm_err} !== '0) begin
      n_fail++; $display("FAIL illegal_post_reset: got %h want 0", {p_integ, p_cnsty, integ_ack, cnsty_ack, chk_cnt, wdog_to, fsm_err});
    end
    integ_req = 4'b1111;
    @(negedge clk);
    n_checks++;
    if (p_integ !== 4'b0001) begin
      n_fail++; $display("FAIL ptr_restart: got %b want 0001", p_integ);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_integ_priority();
    test_busy();
    test_escalation();
    test_watchdog();
    test_illegal_state();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/otp_ctrl_chk_sched.md
Name: otp_ctrl_chk_sched

Overview:
- Sequencer between the periodic check timer and the OTP partitions.
- The timer raises integrity/consistency check requests towards all partitions at once. This block serialises them so only one partition runs a check on the shared OTP macro at a time.
- Arbitration is round-robin across partitions, with integrity checks taking priority over consistency checks.
- Per-partition acks are returned to the timer, checks are held off during programming operations, and the block drops into a terminal error state on escalation or FSM corruption.

Parameters:
- NumReq, 10, number of partitions/requesters (1..32).
- WdogWidth, 32, width of the per-grant watchdog counter (optional feature only).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- integ_req_i  in  NumReq  level integrity requests from the timer; each bit is held until acked.
- cnsty_req_i  in  NumReq  level consistency requests from the timer; each bit is held until acked.
- integ_ack_o  out  NumReq  one-cycle ack pulse per partition, to the timer.
- cnsty_ack_o  out  NumReq  one-cycle ack pulse per partition, to the timer.
- part_integ_req_o  out  NumReq  onehot0 integrity grant to a partition.
- part_cnsty_req_o  out  NumReq  onehot0 consistency grant to a partition.
- part_done_i  in  NumReq  partition check-complete pulse.
- otp_prog_busy_i  in  1  DAI/LCI programming in progress; blocks new grants.
- timeout_i  in  32  watchdog load value; 0 = watchdog disabled.
- escalate_en_i  in  lc_tx_t  escalation input.
- chk_cnt_o  out  16  saturating count of completed checks.
- wdog_timeout_o  out  1  sticky watchdog expiry flag.
- fsm_err_o  out  1  invalid state or escalation.

Behaviour:
- Reset values: all outputs 0; RR pointer 0; state IdleSt; chk_cnt_o 0.
- State machine: IdleSt, IntegGntSt, CnstyGntSt, ErrorSt. Use a sparse encoding with minimum Hamming distance >= 3, registered with the sparse FSM flop macro.
- IdleSt, when !otp_prog_busy_i:
  - If |integ_req_i: pick idx = first set bit at or above ptr, wrapping modulo NumReq. Latch idx and go to IntegGntSt.
  - Else if |cnsty_req_i: same selection, go to CnstyGntSt.
  - Otherwise stay in IdleSt.
- IdleSt, when otp_prog_busy_i=1: stay in IdleSt.
- Grant outputs are registered from the state and idx. If a request is sampled in cycle 0, part_*_req_o[idx]=1 from cycle 1.
- IntegGntSt / CnstyGntSt:
  - Hold part_*_req_o[idx] high until part_done_i[idx]=1, sampled in cycle k.
  - In cycle k+1: the matching *_ack_o[idx] pulses for exactly 1 cycle, grant drops, state returns to IdleSt, ptr = (idx+1) mod NumReq, chk_cnt_o increments (saturating at 0xFFFF).
  - The earliest next grant is cycle k+2.
- part_done_i on a non-granted index, or while in IdleSt: ignored.
- Request bit deasserted mid-grant: the grant is still held until done, and the ack still pulses (the timer masks it).
- otp_prog_busy_i asserted mid-grant: the grant is not interrupted; busy only blocks new grants.
- Integrity and consistency request for the same index in the same cycle: integrity is served first; consistency is served on a later IdleSt visit.
- ErrorSt (terminal):
  - Entered from any state when lc_tx_test_true_loose(escalate_en_i), or from the default branch on an invalid state encoding.
  - fsm_err_o=1 on entry and is held.
  - All grants and acks are forced to 0.
  - Only reset exits ErrorSt.
- Outputs are never X after reset; each grant vector is onehot0, and integ and cnsty grants are never both nonzero.

Optional Feature:
- Macro OTP_CTRL_CHK_SCHED_WDOG_EN.
- Defined:
  - A WdogWidth down-counter loads timeout_i on each grant and decrements every cycle while in a grant state.
  - If timeout_i != 0 and the counter reaches 0 before done: go to ErrorSt, wdog_timeout_o=1 (sticky until reset), fsm_err_o stays 0 unless escalation also occurs.
  - A done in the same cycle as expiry counts as done (no timeout).
- Not defined: wdog_timeout_o is tied to 0, timeout_i is unused (XOR-reduced to an unused signal), and no counter is built.

Test Plan:
- NumReq=4, integ_req_i=4'b1011 held, done returned 2 cycles after each grant -> grants in order idx 0,1,3; integ_ack_o pulses 4'b0001, 4'b0010, 4'b1000; chk_cnt_o=3.
- integ_req_i=4'b0100 and cnsty_req_i=4'b0100 raised in the same cycle -> part_integ_req_o=4'b0100 first; after its ack, part_cnsty_req_o=4'b0100.
- otp_prog_busy_i=1 and cnsty_req_i=4'b0001 -> no grant while busy; grant appears 1 cycle after busy falls. Busy raised mid-grant -> grant is held until done.
- escalate_en_i=On during an active grant -> next cycle state is ErrorSt, fsm_err_o=1, all grants 0, later requests ignored.
- WDOG_EN defined, timeout_i=5, no done returned -> wdog_timeout_o=1 within 6 cycles of the grant, grant drops. With timeout_i=0 -> the grant holds indefinitely.
- Force an illegal state encoding, then assert rst_ni=0 mid-grant -> fsm_err_o=1 and ErrorSt; after reset, all outputs are 0 and ptr restarts at 0.
